// File: rtl/pos_accum_if.sv
// Signal bundle for pos_accum: step/load controls in, position and status flags out.
// master drives the controls; slave is the accumulator side.
interface pos_accum_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] delta;
   logic             Enable;
   logic             Load;
   logic [WIDTH-1:0] LoadValue;
   logic [WIDTH-1:0] pos;
   logic             AtMin;
   logic             AtMax;
   logic             Step;

   modport master (
      output delta, Enable, Load, LoadValue,
      input  pos, AtMin, AtMax, Step
   );

   modport slave (
      input  delta, Enable, Load, LoadValue,
      output pos, AtMin, AtMax, Step
   );
endinterface

// File: rtl/pos_accum.sv
// Saturating position accumulator: a prescaled tick adds a signed delta to an
// unsigned position clamped to [PMIN, PMAX]; Load overrides the tick.
module pos_accum #(
   parameter int               WIDTH = 8,
   parameter int               DIV   = 4,
   parameter logic [WIDTH-1:0] PMIN  = 8'd0,
   parameter logic [WIDTH-1:0] PMAX  = 8'd159,
   parameter logic [WIDTH-1:0] PINIT = 8'd80
) (
   input logic         Clock,
   input logic         Clear,
   pos_accum_if.slave  bus
);
   localparam int         SW       = WIDTH + 2;
   localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic             at_min_q, at_max_q, step_q, step_d;
   logic             tick;
   logic signed [SW-1:0] sum_s, load_s;

   // Two guard bits keep the sum from wrapping before the clamp sees it.
   function automatic logic [WIDTH-1:0] clamp(input logic signed [SW-1:0] v);
      if (v < $signed({2'b00, PMIN}))
         return PMIN;
      else if (v > $signed({2'b00, PMAX}))
         return PMAX;
      else
         return v[WIDTH-1:0];
   endfunction

   assign tick   = bus.Enable && (cnt_q == CNT_LAST);
   assign sum_s  = $signed({2'b00, pos_q}) + $signed({{2{bus.delta[WIDTH-1]}}, bus.delta});
   assign load_s = $signed({2'b00, bus.LoadValue});

   always_comb begin
      cnt_d = cnt_q;
      pos_d = pos_q;
      if (Clear) begin
         pos_d = PINIT;
         cnt_d = '0;
      end else if (bus.Load) begin
         pos_d = clamp(load_s);
         cnt_d = '0;
      end else if (tick) begin
         pos_d = clamp(sum_s);
         cnt_d = '0;
      end else if (bus.Enable) begin
         cnt_d = cnt_q + 8'd1;
      end
      // Clear guard keeps Step defined even while pos_q is still unknown.
      step_d = !Clear && (pos_d != pos_q);
   end

   always_ff @(posedge Clock) begin
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      at_min_q <= (pos_d == PMIN);
      at_max_q <= (pos_d == PMAX);
      step_q   <= step_d;
   end

   assign bus.pos   = pos_q;
   assign bus.AtMin = at_min_q;
   assign bus.AtMax = at_max_q;
   assign bus.Step  = step_q;
endmodule

// File: tb/tb_pos_accum.sv
// Directed bench for pos_accum with default parameters (DIV=4, range 0..159, init 80).
module tb_pos_accum;
   logic Clock;
   logic Clear;
   int   checks = 0;
   int   errors = 0;

   pos_accum_if #(.WIDTH(8)) bus ();

   pos_accum dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end else begin
         $display("ok   %s obs=%0d", tag, obs);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic flags(input string tag, input int p, input bit mn, input bit mx, input bit st);
      check({tag, ".pos"}, bus.pos, p);
      check({tag, ".AtMin"}, bus.AtMin, mn);
      check({tag, ".AtMax"}, bus.AtMax, mx);
      check({tag, ".Step"}, bus.Step, st);
   endtask

   task automatic load(input logic [7:0] v);
      bus.Enable = 1'b0;
      bus.Load = 1'b1;
      bus.LoadValue = v;
      cyc(1);
      bus.Load = 1'b0;
   endtask

   initial begin
      Clear = 1'b1;
      bus.delta = 8'h00;
      bus.Enable = 1'b0;
      bus.Load = 1'b0;
      bus.LoadValue = 8'h00;
      @(posedge Clock);
      #1;
      cyc(1);
      flags("reset", 80, 0, 0, 0);
      Clear = 1'b0;

      // Basic counting: +1 every 4 enabled cycles
      bus.Enable = 1'b1;
      bus.delta = 8'h01;
      cyc(3);
      flags("pre_tick", 80, 0, 0, 0);
      cyc(1);
      flags("tick1", 81, 0, 0, 1);
      cyc(1);
      flags("after_tick1", 81, 0, 0, 0);
      cyc(3);
      flags("tick2", 82, 0, 0, 1);

      // Underflow clamp to PMIN; delta ignored outside tick cycle
      load(8'd2);
      flags("load2", 2, 0, 0, 1);
      bus.Enable = 1'b1;
      bus.delta = 8'h40;
      cyc(3);
      flags("nontick_delta", 2, 0, 0, 0);
      bus.delta = 8'hFD;
      cyc(1);
      flags("clamp_min", 0, 1, 0, 1);
      cyc(4);
      flags("hold_min", 0, 1, 0, 0);

      // Overflow clamp to PMAX without wrap
      load(8'd158);
      bus.Enable = 1'b1;
      bus.delta = 8'h7F;
      cyc(4);
      flags("clamp_max", 159, 0, 1, 1);

      // Load beats tick, is clamped, and restarts the prescaler
      load(8'd100);
      bus.Enable = 1'b1;
      bus.delta = 8'h01;
      cyc(3);
      bus.Load = 1'b1;
      bus.LoadValue = 8'd200;
      cyc(1);
      bus.Load = 1'b0;
      flags("load_prio", 159, 0, 1, 1);
      bus.delta = 8'hFF;
      cyc(3);
      flags("load_cnt0", 159, 0, 1, 0);
      cyc(1);
      flags("tick_after_load", 158, 0, 0, 1);

      // Enable hold at cnt=2
      cyc(2);
      bus.Enable = 1'b0;
      cyc(10);
      flags("hold", 158, 0, 0, 0);
      bus.Enable = 1'b1;
      cyc(1);
      check("resume1.pos", bus.pos, 158);
      cyc(1);
      flags("resume_tick", 157, 0, 0, 1);

      // Load of current value gives no Step
      load(8'd157);
      flags("load_same", 157, 0, 0, 0);

      // Clear mid-count beats Load and discards the partial prescale
      bus.Enable = 1'b1;
      bus.delta = 8'h01;
      cyc(2);
      Clear = 1'b1;
      bus.Load = 1'b1;
      bus.LoadValue = 8'd10;
      cyc(1);
      Clear = 1'b0;
      bus.Load = 1'b0;
      flags("clear_load", 80, 0, 0, 0);
      cyc(3);
      check("clear_cnt0.pos", bus.pos, 80);
      cyc(1);
      flags("clear_tick", 81, 0, 0, 1);

      // Zero delta on tick: no change, no Step
      bus.delta = 8'h00;
      cyc(4);
      flags("zero_delta", 81, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
